audio_adc_rx: RTL and testbench

- I2S capture path for the codec ADC line. Deserialises AUD_ADCDAT into signed left/right samples, using the codec's AUD_BCLK and AUD_ADCLRCK as data-rate timing only; all logic runs on one fast system clock.
- Produces one valid strobe per stereo frame. This gives the mesh/FDN logic a registered, handshaked audio input on the same clock it uses for the rest of the audio path.

---
 rtl/audio_adc_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_audio_adc_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc_rx.sv
// audio_adc_rx
// I2S capture path for the codec ADC line. The codec's BCLK, LRCK and data
// lines are resynchronised into iCLK and used only as data-rate timing; all
// state runs on iCLK. Completed left/right words are paired and presented
// together with a one-cycle oValid strobe.
//
// Ports
//   iCLK          system clock (>= 4x BCLK)
//   iRST_N        asynchronous active-low reset
//   iAUD_BCK      codec bit clock (async)
//   iAUD_ADCLRCK  codec LR clock, low = left, high = right (async)
//   iAUD_ADCDAT   codec serial data, MSB first (async)
//   oAUD_inL/R    last complete left/right pair, two's complement
//   oValid        one-cycle pulse when a new pair is presented
//   oFrameErr     one-cycle pulse when a word is cut short by an LR edge
//   oBitCnt       bits captured in the current word (debug)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset, waiting for the first LR edge
// SKIP     | LR edge seen, skipping the I2S delay slot(s) before the MSB
// SHIFT    | shifting word bits in, MSB first
// DONE     | word committed, ignoring trailing slot bits until next edge

module audio_adc_rx #(
   parameter int DATA_WIDTH  = 16,
   parameter int I2S_DELAY   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  iCLK,
   input  logic                  iRST_N,
   input  logic                  iAUD_BCK,
   input  logic                  iAUD_ADCLRCK,
   input  logic                  iAUD_ADCDAT,
   output logic [DATA_WIDTH-1:0] oAUD_inL,
   output logic [DATA_WIDTH-1:0] oAUD_inR,
   output logic                  oValid,
   output logic                  oFrameErr,
   output logic [5:0]            oBitCnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SKIP  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int SKW      = (I2S_DELAY > 1) ? $clog2(I2S_DELAY) : 1;
   localparam int SKIP_LD  = (I2S_DELAY > 0) ? I2S_DELAY - 1 : 0;

   logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
   logic [SYNC_STAGES-1:0] lr_sync_q, lr_sync_d;
   logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
   logic                   bck_prev_q, bck_prev_d;
   logic                   lr_prev_q, lr_prev_d;
   logic                   primed_q, primed_d;

   logic [1:0]             state_q, state_d;
   logic [5:0]             bit_cnt_q, bit_cnt_d;
   logic [SKW-1:0]         skip_cnt_q, skip_cnt_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic                   chan_q, chan_d;
   logic [DATA_WIDTH-1:0]  stage_q, stage_d;
   logic                   staged_q, staged_d;
   logic [DATA_WIDTH-1:0]  out_l_q, out_l_d;
   logic [DATA_WIDTH-1:0]  out_r_q, out_r_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;

   logic                   bck_s, lr_s, dat_s;
   logic                   bck_rise, lr_edge;
   logic [DATA_WIDTH-1:0]  word;
   logic                   do_capture, do_start, completed;

   // All three lines use the same depth so LRCK/DAT stay aligned to BCK.
   always_comb begin
      bck_sync_d = {bck_sync_q[SYNC_STAGES-2:0], iAUD_BCK};
      lr_sync_d  = {lr_sync_q[SYNC_STAGES-2:0], iAUD_ADCLRCK};
      dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], iAUD_ADCDAT};
      bck_s      = bck_sync_q[SYNC_STAGES-1];
      lr_s       = lr_sync_q[SYNC_STAGES-1];
      dat_s      = dat_sync_q[SYNC_STAGES-1];
      bck_prev_d = bck_s;
      bck_rise   = bck_s & ~bck_prev_q;
      // The first bck_rise after reset only samples LRCK, so a stream that
      // is already mid-right-channel is not mistaken for a word start.
      lr_edge    = bck_rise & primed_q & (lr_s ^ lr_prev_q);
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      skip_cnt_d = skip_cnt_q;
      shift_d    = shift_q;
      chan_d     = chan_q;
      stage_d    = stage_q;
      staged_d   = staged_q;
      out_l_d    = out_l_q;
      out_r_d    = out_r_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      lr_prev_d  = lr_prev_q;
      primed_d   = primed_q;
      word       = {shift_q[DATA_WIDTH-2:0], dat_s};
      do_capture = 1'b0;
      do_start   = 1'b0;
      completed  = 1'b0;

      if (bck_rise) begin
         lr_prev_d = lr_s;
         primed_d  = 1'b1;
         case (state_q)
            ST_IDLE: do_start = lr_edge;
            ST_SKIP: begin
               if (lr_edge) begin
                  err_d    = 1'b1;
                  staged_d = 1'b0;
                  do_start = 1'b1;
               end else if (skip_cnt_q == '0) begin
                  do_capture = 1'b1;
               end else begin
                  skip_cnt_d = skip_cnt_q - 1'b1;
               end
            end
            ST_SHIFT: begin
               do_capture = 1'b1;
               completed  = (bit_cnt_q == 6'(DATA_WIDTH - 1));
               // An edge on the final bit still commits the word; the same
               // edge then opens the next word.
               if (lr_edge) begin
                  do_start = 1'b1;
                  if (!completed) begin
                     err_d    = 1'b1;
                     staged_d = 1'b0;
                  end
               end
            end
            default: do_start = lr_edge;
         endcase
      end

      if (do_capture) begin
         shift_d   = word;
         bit_cnt_d = bit_cnt_q + 1'b1;
         state_d   = ST_SHIFT;
         if (completed) begin
            state_d = ST_DONE;
            if (!chan_q) begin
               stage_d  = word;
               staged_d = 1'b1;
            end else if (staged_q) begin
               out_l_d  = stage_q;
               out_r_d  = word;
               valid_d  = 1'b1;
               staged_d = 1'b0;
            end
         end
      end

      if (do_start) begin
         chan_d = lr_s;
         if (I2S_DELAY == 0) begin
            // Left-justified: the bit on the edge itself is the MSB.
            shift_d   = {{(DATA_WIDTH-1){1'b0}}, dat_s};
            bit_cnt_d = 6'd1;
            state_d   = ST_SHIFT;
         end else begin
            shift_d    = '0;
            bit_cnt_d  = '0;
            skip_cnt_d = SKW'(SKIP_LD);
            state_d    = ST_SKIP;
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         bck_sync_q <= '0;
         lr_sync_q  <= '0;
         dat_sync_q <= '0;
         bck_prev_q <= 1'b0;
         lr_prev_q  <= 1'b0;
         primed_q   <= 1'b0;
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         skip_cnt_q <= '0;
         shift_q    <= '0;
         chan_q     <= 1'b0;
         stage_q    <= '0;
         staged_q   <= 1'b0;
         out_l_q    <= '0;
         out_r_q    <= '0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         bck_sync_q <= bck_sync_d;
         lr_sync_q  <= lr_sync_d;
         dat_sync_q <= dat_sync_d;
         bck_prev_q <= bck_prev_d;
         lr_prev_q  <= lr_prev_d;
         primed_q   <= primed_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         skip_cnt_q <= skip_cnt_d;
         shift_q    <= shift_d;
         chan_q     <= chan_d;
         stage_q    <= stage_d;
         staged_q   <= staged_d;
         out_l_q    <= out_l_d;
         out_r_q    <= out_r_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
      end
   end

   assign oAUD_inL  = out_l_q;
   assign oAUD_inR  = out_r_q;
   assign oValid    = valid_q;
   assign oFrameErr = err_q;
   assign oBitCnt   = bit_cnt_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed + random bench for audio_adc_rx. Two instances share the serial
// stream: dut (standard I2S, one delay slot) and dut0 (left-justified).
// Expected samples come straight from the words the bench serialises.

module tb_audio_adc_rx;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        bck = 1'b0, lrck = 1'b0, dat = 1'b0;

   logic [15:0] o_l, o_r, o0_l, o0_r;
   logic        o_v, o_e, o0_v, o0_e;
   logic [5:0]  o_bc, o0_bc;

   int          n_assert = 0;
   int          n_fail = 0;
   int          hp = 4;
   longint      cyc = 0;

   logic [15:0] ql[$], qr[$], q0l[$], q0r[$], el[$], er[$];
   longint      qt[$];
   int          err_cnt = 0, dbl = 0;
   logic        prev_v = 1'b0;

   always #5 iCLK = ~iCLK;
   always @(posedge iCLK) cyc <= cyc + 1;

   audio_adc_rx #(.DATA_WIDTH(16), .I2S_DELAY(1), .SYNC_STAGES(2)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iAUD_BCK(bck), .iAUD_ADCLRCK(lrck),
      .iAUD_ADCDAT(dat), .oAUD_inL(o_l), .oAUD_inR(o_r), .oValid(o_v),
      .oFrameErr(o_e), .oBitCnt(o_bc));

   audio_adc_rx #(.DATA_WIDTH(16), .I2S_DELAY(0), .SYNC_STAGES(2)) dut0 (
      .iCLK(iCLK), .iRST_N(iRST_N), .iAUD_BCK(bck), .iAUD_ADCLRCK(lrck),
      .iAUD_ADCDAT(dat), .oAUD_inL(o0_l), .oAUD_inR(o0_r), .oValid(o0_v),
      .oFrameErr(o0_e), .oBitCnt(o0_bc));

   always @(negedge iCLK) begin
      if (o_v) begin
         ql.push_back(o_l);
         qr.push_back(o_r);
         qt.push_back(cyc);
      end
      if (o0_v) begin
         q0l.push_back(o0_l);
         q0r.push_back(o0_r);
      end
      if (o_v && prev_v) dbl <= dbl + 1;
      if (o_e) err_cnt <= err_cnt + 1;
      prev_v <= o_v;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One BCLK period: LRCK/DAT change while BCK is low, sampled on the rise.
   task automatic bit_out(input logic l, input logic d);
      @(negedge iCLK);
      bck = 1'b0; lrck = l; dat = d;
      repeat (hp) @(negedge iCLK);
      bck = 1'b1;
      repeat (hp - 1) @(negedge iCLK);
   endtask

   // Half-frame of nbits slots; word MSB sits d slots after the LR edge.
   task automatic send_half(input logic ch, input logic [15:0] w, input int d,
                            input int nbits, input bit rnd_junk);
      logic b;
      for (int k = 0; k < nbits; k++) begin
         if (k >= d && k < d + 16) b = w[15 - (k - d)];
         else b = rnd_junk ? 1'($urandom_range(0, 1)) : 1'b0;
         bit_out(ch, b);
      end
   endtask

   task automatic clear_q();
      ql.delete(); qr.delete(); qt.delete(); q0l.delete(); q0r.delete();
   endtask

   initial begin
      int e0, d0, nf;
      longint dt;
      logic [15:0] rl, rr;

      repeat (5) @(negedge iCLK);
      chk("rst_l", 32'(o_l), 32'h0);
      chk("rst_r", 32'(o_r), 32'h0);
      chk("rst_valid", 32'(o_v), 32'h0);
      chk("rst_err", 32'(o_e), 32'h0);
      chk("rst_bitcnt", 32'(o_bc), 32'h0);
      iRST_N = 1'b1;
      repeat (3) @(negedge iCLK);

      // First word after reset is right: it must not pair with anything.
      e0 = err_cnt;
      send_half(1'b0, 16'h0000, 1, 4, 1'b0);
      send_half(1'b1, 16'h1234, 1, 32, 1'b1);
      repeat (10) @(negedge iCLK);
      chk("first_right_novalid", 32'(ql.size()), 32'd0);
      send_half(1'b0, 16'hABCD, 1, 32, 1'b1);
      send_half(1'b1, 16'h5555, 1, 32, 1'b1);
      repeat (10) @(negedge iCLK);
      chk("pair1_count", 32'(ql.size()), 32'd1);
      if (ql.size() > 0) begin
         chk("pair1_l", 32'(ql[0]), 32'hABCD);
         chk("pair1_r", 32'(qr[0]), 32'h5555);
      end
      chk("pair1_err", 32'(err_cnt - e0), 32'd0);
      clear_q();

      // Nominal I2S frame.
      send_half(1'b0, 16'h8001, 1, 32, 1'b1);
      send_half(1'b1, 16'h7FFE, 1, 32, 1'b1);
      repeat (10) @(negedge iCLK);
      chk("nom_count", 32'(ql.size()), 32'd1);
      if (ql.size() > 0) begin
         chk("nom_l", 32'(ql[0]), 32'h8001);
         chk("nom_r", 32'(qr[0]), 32'h7FFE);
      end
      chk("nom_err", 32'(err_cnt - e0), 32'd0);
      clear_q();

      // Left word cut after 9 bits.
      e0 = err_cnt;
      send_half(1'b0, 16'hAAAA, 1, 10, 1'b1);
      send_half(1'b1, 16'h3C3C, 1, 32, 1'b1);
      repeat (10) @(negedge iCLK);
      chk("trunc_err", 32'(err_cnt - e0), 32'd1);
      chk("trunc_novalid", 32'(ql.size()), 32'd0);
      chk("trunc_hold_l", 32'(o_l), 32'h8001);
      chk("trunc_hold_r", 32'(o_r), 32'h7FFE);
      send_half(1'b0, 16'h1357, 1, 32, 1'b1);
      send_half(1'b1, 16'h2468, 1, 32, 1'b1);
      repeat (10) @(negedge iCLK);
      chk("recover_count", 32'(ql.size()), 32'd1);
      if (ql.size() > 0) begin
         chk("recover_l", 32'(ql[0]), 32'h1357);
         chk("recover_r", 32'(qr[0]), 32'h2468);
      end
      chk("recover_err", 32'(err_cnt - e0), 32'd1);
      clear_q();

      // Left-justified stream: exact on dut0, shifted left by one on dut.
      send_half(1'b0, 16'hF00F, 0, 32, 1'b0);
      send_half(1'b1, 16'h0FF0, 0, 32, 1'b0);
      repeat (10) @(negedge iCLK);
      chk("lj_d0_count", 32'(q0l.size()), 32'd1);
      if (q0l.size() > 0) begin
         chk("lj_d0_l", 32'(q0l[0]), 32'hF00F);
         chk("lj_d0_r", 32'(q0r[0]), 32'h0FF0);
      end
      chk("lj_d1_count", 32'(ql.size()), 32'd1);
      if (ql.size() > 0) begin
         chk("lj_d1_l", 32'(ql[0]), 32'((32'hF00F << 1) & 32'hFFFF));
         chk("lj_d1_r", 32'(qr[0]), 32'((32'h0FF0 << 1) & 32'hFFFF));
      end
      clear_q();

      // Asynchronous reset in the middle of a word (7 bits captured).
      send_half(1'b0, 16'hC3A5, 1, 8, 1'b1);
      repeat (6) @(negedge iCLK);
      chk("mid_bitcnt", 32'(o_bc), 32'd7);
      #2 iRST_N = 1'b0;
      #1;
      chk("arst_l", 32'(o_l), 32'h0);
      chk("arst_r", 32'(o_r), 32'h0);
      chk("arst_bitcnt", 32'(o_bc), 32'h0);
      chk("arst_d0_l", 32'(o0_l), 32'h0);
      repeat (3) @(negedge iCLK);
      iRST_N = 1'b1;
      send_half(1'b1, 16'h9999, 1, 32, 1'b1);
      send_half(1'b0, 16'h1111, 1, 32, 1'b1);
      send_half(1'b1, 16'h2222, 1, 32, 1'b1);
      repeat (10) @(negedge iCLK);
      chk("post_rst_count", 32'(ql.size()), 32'd1);
      if (ql.size() > 0) begin
         chk("post_rst_l", 32'(ql[0]), 32'h1111);
         chk("post_rst_r", 32'(qr[0]), 32'h2222);
      end
      clear_q();

      // Back-to-back random frames at BCLK = iCLK/4, 20-slot half-frames.
      hp = 2;
      nf = 300;
      e0 = err_cnt;
      d0 = dbl;
      for (int f = 0; f < nf; f++) begin
         rl = 16'($urandom);
         rr = 16'($urandom);
         el.push_back(rl);
         er.push_back(rr);
         send_half(1'b0, rl, 1, 20, 1'b1);
         send_half(1'b1, rr, 1, 20, 1'b1);
      end
      repeat (20) @(negedge iCLK);
      chk("rand_count", 32'(ql.size()), 32'(nf));
      for (int i = 0; i < nf && i < ql.size(); i++) begin
         chk($sformatf("rand_l[%0d]", i), 32'(ql[i]), 32'(el[i]));
         chk($sformatf("rand_r[%0d]", i), 32'(qr[i]), 32'(er[i]));
      end
      for (int i = 1; i < qt.size(); i++) begin
         dt = qt[i] - qt[i-1];
         chk($sformatf("rand_spacing[%0d]", i), 32'(dt >= 159 && dt <= 161), 32'd1);
      end
      chk("rand_err", 32'(err_cnt - e0), 32'd0);
      chk("valid_width", 32'(dbl - d0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
